// File: rtl/packet_switch_dbg_cntr_rd.sv
// Packet switch debug event counters with atomic snapshot and a pipelined Avalon-MM read agent.
// Optional macro PKT_SW_DBG_CNTR_CLR_ON_SNAP_EN: each SNAP also clears live counters and sat_o.
module packet_switch_dbg_cntr_rd #(
  parameter int CNTR_WIDTH = 32,
  parameter int NUM_CNTR   = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CNTR-1:0]   event_i,
  input  logic [ADDR_WIDTH-1:0] avmm_address,
  input  logic                  avmm_read,
  input  logic                  avmm_write,
  input  logic [31:0]           avmm_writedata,
  output logic [31:0]           avmm_readdata,
  output logic                  avmm_readdatavalid,
  output logic                  avmm_waitrequest,
  output logic [NUM_CNTR-1:0]   sat_o
);

  localparam logic [CNTR_WIDTH-1:0] CNT_MAX = '1;

  logic [CNTR_WIDTH-1:0] cnt  [NUM_CNTR];
  logic [CNTR_WIDTH-1:0] snap [NUM_CNTR];
  logic [NUM_CNTR-1:0]   sat;
  logic [15:0]           seq;
  logic                  freeze;
  logic                  wait_q;

  logic                  wr_ok;
  logic                  rd_ok;
  logic                  ctrl_wr;
  logic                  do_snap;
  logic                  do_clr;
  logic [NUM_CNTR-1:0]   inc;
  logic [31:0]           addr32;
  logic [31:0]           rd_mux;
  logic                  rd_v1;
  logic [31:0]           rd_d1;
  logic                  unused_wdata;

  assign wr_ok   = avmm_write & ~wait_q;
  assign rd_ok   = avmm_read & ~wait_q;
  assign ctrl_wr = wr_ok && (avmm_address == '0);
  assign do_snap = ctrl_wr & avmm_writedata[0];
`ifdef PKT_SW_DBG_CNTR_CLR_ON_SNAP_EN
  assign do_clr  = ctrl_wr & (avmm_writedata[1] | avmm_writedata[0]);
`else
  assign do_clr  = ctrl_wr & avmm_writedata[1];
`endif
  assign inc          = event_i & {NUM_CNTR{~freeze}};
  assign addr32       = 32'(avmm_address);
  assign unused_wdata = ^avmm_writedata[31:3];

  // Snapshot always sees the pre-update counter; a clear keeps a same-cycle event as count 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: counter and snapshot arrays are architecturally visible after reset, so they are reset, not left as RAM.
      for (int n = 0; n < NUM_CNTR; n++) begin
        cnt[n]  <= '0;
        snap[n] <= '0;
      end
      sat <= '0;
    end else begin
      for (int n = 0; n < NUM_CNTR; n++) begin
        if (do_snap) snap[n] <= cnt[n];
        if (do_clr) begin
          cnt[n] <= inc[n] ? CNTR_WIDTH'(1) : '0;
          sat[n] <= 1'b0;
        end else if (inc[n]) begin
          if (cnt[n] == CNT_MAX) sat[n] <= 1'b1;
          else                   cnt[n] <= cnt[n] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq    <= '0;
      freeze <= 1'b0;
      wait_q <= 1'b1;
    end else begin
      wait_q <= 1'b0;
      if (do_snap) seq <= seq + 16'd1;
      if (ctrl_wr) freeze <= avmm_writedata[2];
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns rd_mux and no latch is inferred.
    rd_mux = '0;
    case (addr32)
      32'h0:   rd_mux = {29'd0, freeze, 2'd0};
      32'h1:   rd_mux = {|sat, 15'd0, seq};
      32'h2:   rd_mux = {8'd0, 8'(CNTR_WIDTH), 16'(NUM_CNTR)};
      32'h3:   rd_mux = '0;
      default: begin
        for (int n = 0; n < NUM_CNTR; n++) begin
          if (addr32 == 32'(4 + n)) rd_mux = 32'(snap[n]);
        end
      end
    endcase
  end

  // Stage 1 captures the decoded word in the accept cycle, so a same-cycle write returns pre-write data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v1              <= 1'b0;
      rd_d1              <= '0;
      avmm_readdatavalid <= 1'b0;
      avmm_readdata      <= '0;
    end else begin
      rd_v1              <= rd_ok;
      rd_d1              <= rd_ok ? rd_mux : '0;
      avmm_readdatavalid <= rd_v1;
      avmm_readdata      <= rd_v1 ? rd_d1 : '0;
    end
  end

  assign avmm_waitrequest = wait_q;
  assign sat_o            = sat;

endmodule

// File: tb/tb_packet_switch_dbg_cntr_rd.sv
// Directed bench for packet_switch_dbg_cntr_rd: a default instance and a CNTR_WIDTH=4 instance on a shared bus.
module tb_packet_switch_dbg_cntr_rd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  ev, ev4, addr, sat, sat4;
  logic        rd_r, wr_r, rvalid, rvalid4, wreq, wreq4;
  logic [31:0] wdata, rdata, rdata4, d, d4;
  int          vec_cnt = 0;
  int          err_cnt = 0;
  int          seq_exp = 0;

  always #5 clk = ~clk;

  packet_switch_dbg_cntr_rd u_dut (
    .clk(clk), .rst_n(rst_n), .event_i(ev), .avmm_address(addr),
    .avmm_read(rd_r), .avmm_write(wr_r), .avmm_writedata(wdata),
    .avmm_readdata(rdata), .avmm_readdatavalid(rvalid),
    .avmm_waitrequest(wreq), .sat_o(sat)
  );

  packet_switch_dbg_cntr_rd #(.CNTR_WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .event_i(ev4), .avmm_address(addr),
    .avmm_read(rd_r), .avmm_write(wr_r), .avmm_writedata(wdata),
    .avmm_readdata(rdata4), .avmm_readdatavalid(rvalid4),
    .avmm_waitrequest(wreq4), .sat_o(sat4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] dat);
    @(negedge clk);
    addr = a; wdata = dat; wr_r = 1'b1;
    @(negedge clk);
    wr_r = 1'b0; wdata = '0;
    if (a == 8'h0 && dat[0]) seq_exp++;
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [31:0] q, output logic [31:0] q4);
    @(negedge clk);
    addr = a; rd_r = 1'b1;
    @(negedge clk);
    rd_r = 1'b0;
    check("valid_at_1", 32'(rvalid), 32'd0);
    @(negedge clk);
    check("valid_at_2", 32'(rvalid), 32'd1);
    check("valid4_at_2", 32'(rvalid4), 32'd1);
    q = rdata; q4 = rdata4;
  endtask

  task automatic pulse(input logic [7:0] e, input logic [7:0] e4, input int n);
    repeat (n) begin
      @(negedge clk);
      ev = e; ev4 = e4;
    end
    @(negedge clk);
    ev = '0; ev4 = '0;
  endtask

  initial begin
    rst_n = 1'b0; ev = '0; ev4 = '0; addr = '0; rd_r = 1'b0; wr_r = 1'b0; wdata = '0;

    // Reset values and waitrequest release
    repeat (2) @(negedge clk);
    check("rst_wreq", 32'(wreq), 32'd1);
    check("rst_valid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_sat", 32'(sat), 32'd0);
    rst_n = 1'b1;
    check("wreq_before_edge", 32'(wreq), 32'd1);
    @(negedge clk);
    check("wreq_released", 32'(wreq), 32'd0);

    bus_rd(8'h2, d, d4);
    check("param", d, 32'h0020_0008);
    check("param_w4", d4, 32'h0004_0008);
    bus_rd(8'h1, d, d4);
    check("status_rst", d, 32'd0);
    bus_rd(8'h4, d, d4);
    check("snap0_rst", d, 32'd0);

    // Five events on counter 3, then snapshot
    pulse(8'h08, 8'h00, 5);
    bus_wr(8'h0, 32'h1);
    bus_rd(8'h7, d, d4);
    check("snap3_five", d, 32'd5);
    bus_rd(8'h1, d, d4);
    check("seq_one", d, 32'd1);

    // Saturation on the 4-bit instance
    pulse(8'h00, 8'h01, 17);
    bus_wr(8'h0, 32'h1);
    bus_rd(8'h4, d, d4);
    check("w4_snap_sat", d4, 32'hF);
    check("w4_sat_flag", 32'(sat4), 32'h01);
    bus_rd(8'h1, d, d4);
    check("w4_status_sat", d4, 32'h8000_0000 | 32'(seq_exp));
    bus_wr(8'h0, 32'h2);
    check("w4_sat_cleared", 32'(sat4), 32'h00);
    bus_rd(8'h1, d, d4);
    check("w4_status_clr", d4, 32'(seq_exp));

    // CLR_ALL+SNAP write with a coincident event on counter 2 (live count 9)
    pulse(8'h04, 8'h00, 9);
    @(negedge clk);
    addr = 8'h0; wdata = 32'h3; wr_r = 1'b1; ev = 8'h04;
    @(negedge clk);
    wr_r = 1'b0; wdata = '0; ev = '0; seq_exp++;
    bus_rd(8'h6, d, d4);
    check("snap2_preclear", d, 32'd9);
    bus_wr(8'h0, 32'h1);
    bus_rd(8'h6, d, d4);
    check("snap2_event_kept", d, 32'd1);

    // Counter n gets n+1 events, then back-to-back reads of every snapshot
    bus_wr(8'h0, 32'h2);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ev = 8'hFF << k;
    end
    @(negedge clk);
    ev = '0;
    bus_wr(8'h0, 32'h1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("b2b_valid_%0d", c), 32'(rvalid), (c >= 2) ? 32'd1 : 32'd0);
      check($sformatf("b2b_data_%0d", c), rdata, (c >= 2) ? 32'(c - 1) : 32'd0);
      if (c < 8) begin
        addr = 8'(4 + c); rd_r = 1'b1;
      end else begin
        rd_r = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b_idle_valid", 32'(rvalid), 32'd0);
    check("b2b_idle_data", rdata, 32'd0);
    bus_rd(8'hC, d, d4);
    check("beyond_range", d, 32'd0);
    bus_rd(8'h3, d, d4);
    check("reserved", d, 32'd0);

    // Read and write CTRL together: read returns pre-write FREEZE
    @(negedge clk);
    addr = 8'h0; wdata = 32'h4; rd_r = 1'b1; wr_r = 1'b1;
    @(negedge clk);
    rd_r = 1'b0; wr_r = 1'b0; wdata = '0;
    @(negedge clk);
    check("rw_valid", 32'(rvalid), 32'd1);
    check("rw_prewrite", rdata, 32'd0);
    bus_rd(8'h0, d, d4);
    check("ctrl_freeze", d, 32'h4);

    // Events are ignored while frozen
    pulse(8'h02, 8'h00, 3);
    bus_wr(8'h0, 32'h1);
`ifdef PKT_SW_DBG_CNTR_CLR_ON_SNAP_EN
    bus_rd(8'h5, d, d4);
    check("freeze_hold", d, 32'd0);
`else
    bus_rd(8'h5, d, d4);
    check("freeze_hold", d, 32'd2);
`endif

    // Writes to read-only STATUS are ignored
    bus_wr(8'h1, 32'hFFFF_FFFF);
    bus_rd(8'h1, d, d4);
    check("status_ro", d, 32'(seq_exp));

    // Interval counting: 3 events, SNAP, 2 events, SNAP
    bus_wr(8'h0, 32'h2);
    pulse(8'h01, 8'h00, 3);
    bus_wr(8'h0, 32'h1);
    pulse(8'h01, 8'h00, 2);
    bus_wr(8'h0, 32'h1);
    bus_rd(8'h4, d, d4);
`ifdef PKT_SW_DBG_CNTR_CLR_ON_SNAP_EN
    check("interval_snap", d, 32'd2);
`else
    check("interval_snap", d, 32'd5);
`endif

    // Reset while a read is in flight drops the response
    @(negedge clk);
    addr = 8'h4; rd_r = 1'b1;
    @(negedge clk);
    rd_r = 1'b0; rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("midrst_valid", 32'(rvalid), 32'd0);
      check("midrst_rdata", rdata, 32'd0);
      check("midrst_wreq", 32'(wreq), 32'd1);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_valid", 32'(rvalid), 32'd0);
    bus_rd(8'h1, d, d4);
    check("postrst_status", d, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
